// File: rtl/maincore_writeback_stage.sv
// Writeback stage: merges ALU and load results into one registered register-file write port.
// Define WB_FWD_EN to add the writeback-to-operand forwarding ports.
module maincore_writeback_stage #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              alu_valid_in,
  input  logic [4:0]        alu_rd_in,
  input  logic [4:0]        alu_bank_in,
  input  logic [31:0]       alu_val_in,
  input  logic              alu_hi_in,
  input  logic              alu_low_in,
  input  logic              mem_valid_in,
  output logic              mem_ready_out,
  input  logic [4:0]        mem_rd_in,
  input  logic [4:0]        mem_bank_in,
  input  logic [31:0]       mem_val_in,
  input  logic              mem_hi_in,
  input  logic              mem_low_in,
  output logic              wb_out,
  output logic [4:0]        wb_rd_out,
  output logic [4:0]        wb_bank_sel_out,
  output logic [31:0]       wb_val_out,
  output logic              wb_hi_out,
  output logic              wb_low_out,
  output logic [FIFO_AW:0]  pending_out
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]        fwd_rsa_in,
  input  logic [4:0]        fwd_rsb_in,
  input  logic [4:0]        fwd_bank_in,
  output logic              fwd_a_hit_out,
  output logic              fwd_b_hit_out,
  output logic [31:0]       fwd_a_val_out,
  output logic [31:0]       fwd_b_val_out
`endif
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  bank;
    logic [31:0] val;
    logic        hi;
    logic        low;
  } wb_entry_t;

  // Entry e is fully overwritten by ALU write a (same reg, same bank, halves covered).
  function automatic logic waw_hit(input wb_entry_t e, input wb_entry_t a);
    return (e.rd == a.rd) && (e.bank[1:0] == a.bank[1:0]) &&
           !(e.hi && !a.hi) && !(e.low && !a.low);
  endfunction

  wb_entry_t               ent_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   live_q, live_d;
  logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]        count_q, count_d;
  logic [FIFO_AW:0]        pending_q, pending_d;
  logic                    wb_q, wb_d;
  wb_entry_t               out_q, out_d;

  wb_entry_t alu_ent, mem_ent, head_ent;
  logic      mem_acc, fifo_empty, bypass, push, pop, head_live;

  // hi=low=0 means a full-word write; normalise on capture.
  assign alu_ent = '{rd: alu_rd_in, bank: alu_bank_in, val: alu_val_in,
                     hi: alu_hi_in | ~alu_low_in, low: alu_low_in | ~alu_hi_in};
  assign mem_ent = '{rd: mem_rd_in, bank: mem_bank_in, val: mem_val_in,
                     hi: mem_hi_in | ~mem_low_in, low: mem_low_in | ~mem_hi_in};

  assign mem_ready_out = (count_q != (FIFO_AW + 1)'(FIFO_DEPTH));
  assign mem_acc       = mem_valid_in & mem_ready_out;
  assign fifo_empty    = (count_q == '0);
  assign bypass        = mem_acc & fifo_empty & ~alu_valid_in;
  assign push          = mem_acc & ~bypass;
  assign pop           = ~alu_valid_in & ~fifo_empty;
  assign head_ent      = ent_q[rd_ptr_q];
  assign head_live     = live_q[rd_ptr_q];

  always_comb begin
    live_d = live_q;
    if (alu_valid_in) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (live_q[i] && waw_hit(ent_q[i], alu_ent)) begin
          live_d[i] = 1'b0;
        end
      end
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      live_d[wr_ptr_q] = ~(alu_valid_in & waw_hit(mem_ent, alu_ent));
    end

    pending_d = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      pending_d = pending_d + {{FIFO_AW{1'b0}}, live_d[i]};
    end

    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
  end

  // ALU has absolute priority; bypass only happens with an empty FIFO, so it never overtakes.
  always_comb begin
    wb_d  = 1'b0;
    out_d = out_q;
    if (alu_valid_in) begin
      wb_d  = 1'b1;
      out_d = alu_ent;
    end else if (pop && head_live) begin
      wb_d  = 1'b1;
      out_d = head_ent;
    end else if (bypass) begin
      wb_d  = 1'b1;
      out_d = mem_ent;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      live_q    <= '0;
      wb_q      <= 1'b0;
      out_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      live_q    <= live_d;
      wb_q      <= wb_d;
      out_q     <= out_d;
      if (push) begin
        ent_q[wr_ptr_q] <= mem_ent;
      end
    end
  end

  assign wb_out          = wb_q;
  assign wb_rd_out       = out_q.rd;
  assign wb_bank_sel_out = out_q.bank;
  assign wb_val_out      = out_q.val;
  assign wb_hi_out       = out_q.hi;
  assign wb_low_out      = out_q.low;
  assign pending_out     = pending_q;

`ifdef WB_FWD_EN
  logic fwd_base_ok;
  logic unused_fwd_bank;

  assign fwd_base_ok     = wb_q && out_q.hi && out_q.low &&
                           (out_q.bank[1:0] == fwd_bank_in[1:0]);
  assign fwd_a_hit_out   = fwd_base_ok && (out_q.rd == fwd_rsa_in);
  assign fwd_b_hit_out   = fwd_base_ok && (out_q.rd == fwd_rsb_in);
  assign fwd_a_val_out   = fwd_a_hit_out ? out_q.val : 32'h0;
  assign fwd_b_val_out   = fwd_b_hit_out ? out_q.val : 32'h0;
  assign unused_fwd_bank = ^fwd_bank_in[4:2];
`endif

endmodule

// File: tb/tb_maincore_writeback_stage.sv
// Directed bench for maincore_writeback_stage: vector table plus full/reset/forwarding sequences.
module tb_maincore_writeback_stage;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        alu_valid_in, alu_hi_in, alu_low_in;
  logic [4:0]  alu_rd_in, alu_bank_in;
  logic [31:0] alu_val_in;
  logic        mem_valid_in, mem_ready_out, mem_hi_in, mem_low_in;
  logic [4:0]  mem_rd_in, mem_bank_in;
  logic [31:0] mem_val_in;
  logic        wb_out, wb_hi_out, wb_low_out;
  logic [4:0]  wb_rd_out, wb_bank_sel_out;
  logic [31:0] wb_val_out;
  logic [2:0]  pending_out;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_rsa_in, fwd_rsb_in, fwd_bank_in;
  logic        fwd_a_hit_out, fwd_b_hit_out;
  logic [31:0] fwd_a_val_out, fwd_b_val_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  maincore_writeback_stage #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .alu_valid_in    (alu_valid_in),
    .alu_rd_in       (alu_rd_in),
    .alu_bank_in     (alu_bank_in),
    .alu_val_in      (alu_val_in),
    .alu_hi_in       (alu_hi_in),
    .alu_low_in      (alu_low_in),
    .mem_valid_in    (mem_valid_in),
    .mem_ready_out   (mem_ready_out),
    .mem_rd_in       (mem_rd_in),
    .mem_bank_in     (mem_bank_in),
    .mem_val_in      (mem_val_in),
    .mem_hi_in       (mem_hi_in),
    .mem_low_in      (mem_low_in),
    .wb_out          (wb_out),
    .wb_rd_out       (wb_rd_out),
    .wb_bank_sel_out (wb_bank_sel_out),
    .wb_val_out      (wb_val_out),
    .wb_hi_out       (wb_hi_out),
    .wb_low_out      (wb_low_out),
    .pending_out     (pending_out)
`ifdef WB_FWD_EN
    ,
    .fwd_rsa_in      (fwd_rsa_in),
    .fwd_rsb_in      (fwd_rsb_in),
    .fwd_bank_in     (fwd_bank_in),
    .fwd_a_hit_out   (fwd_a_hit_out),
    .fwd_b_hit_out   (fwd_b_hit_out),
    .fwd_a_val_out   (fwd_a_val_out),
    .fwd_b_val_out   (fwd_b_val_out)
`endif
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard, abk;
    logic [31:0] aval;
    logic        ahi, alo;
    logic        mv;
    logic [4:0]  mrd, mbk;
    logic [31:0] mval;
    logic        mhi, mlo;
    logic        ewb;
    logic [4:0]  erd, ebk;
    logic [31:0] eval;
    logic        ehi, elo;
    logic [2:0]  epend;
    logic        erdy;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t v(
      input int unsigned av, ard, abk, input logic [31:0] aval, input int unsigned ahi, alo,
      input int unsigned mv, mrd, mbk, input logic [31:0] mval, input int unsigned mhi, mlo,
      input int unsigned ewb, erd, ebk, input logic [31:0] eval, input int unsigned ehi, elo,
      input int unsigned epend, erdy);
    vec_t r;
    r.av = av[0];   r.ard = ard[4:0]; r.abk = abk[4:0]; r.aval = aval;
    r.ahi = ahi[0]; r.alo = alo[0];
    r.mv = mv[0];   r.mrd = mrd[4:0]; r.mbk = mbk[4:0]; r.mval = mval;
    r.mhi = mhi[0]; r.mlo = mlo[0];
    r.ewb = ewb[0]; r.erd = erd[4:0]; r.ebk = ebk[4:0]; r.eval = eval;
    r.ehi = ehi[0]; r.elo = elo[0];
    r.epend = epend[2:0]; r.erdy = erdy[0];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [4:0] abk,
                       input logic [31:0] aval, input logic ahi, input logic alo,
                       input logic mv, input logic [4:0] mrd, input logic [4:0] mbk,
                       input logic [31:0] mval, input logic mhi, input logic mlo);
    alu_valid_in = av; alu_rd_in = ard; alu_bank_in = abk; alu_val_in = aval;
    alu_hi_in = ahi; alu_low_in = alo;
    mem_valid_in = mv; mem_rd_in = mrd; mem_bank_in = mbk; mem_val_in = mval;
    mem_hi_in = mhi; mem_low_in = mlo;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string nm, input logic [4:0] rd, input logic [31:0] val);
    check({nm, ".wb"}, 32'(wb_out), 32'h1);
    check({nm, ".rd"}, 32'(wb_rd_out), 32'(rd));
    check({nm, ".val"}, wb_val_out, val);
  endtask

  int accepted;

  initial begin
    vecs[0]  = v(1, 5, 0, 32'hDEADBEEF, 0, 0,  0, 0, 0, 0, 0, 0,
                 1, 5, 0, 32'hDEADBEEF, 1, 1,  0, 1);
    vecs[1]  = v(1, 9, 1, 32'h0000ABCD, 0, 1,  0, 0, 0, 0, 0, 0,
                 1, 9, 1, 32'h0000ABCD, 0, 1,  0, 1);
    vecs[2]  = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1);
    vecs[3]  = v(0, 0, 0, 0, 0, 0,  1, 4, 2, 32'h11112222, 1, 0,
                 1, 4, 2, 32'h11112222, 1, 0,  0, 1);
    vecs[4]  = v(1, 6, 0, 32'hA5A5A5A5, 1, 1,  1, 7, 0, 32'h77, 0, 0,
                 1, 6, 0, 32'hA5A5A5A5, 1, 1,  1, 1);
    vecs[5]  = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 7, 0, 32'h77, 1, 1,  0, 1);
    // Same-cycle squash of the incoming low-half load by a full-word ALU write.
    vecs[6]  = v(1, 3, 1, 32'hCAFE0001, 1, 1,  1, 3, 1, 32'h5555, 0, 1,
                 1, 3, 1, 32'hCAFE0001, 1, 1,  0, 1);
    vecs[7]  = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1);
    vecs[8]  = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1);
    vecs[9]  = v(1, 31, 31, 32'hFFFFFFFF, 0, 0,  0, 0, 0, 0, 0, 0,
                 1, 31, 31, 32'hFFFFFFFF, 1, 1,  0, 1);
    vecs[10] = v(1, 2, 0, 32'h00001234, 1, 0,  1, 2, 0, 32'hBBBB0000, 1, 1,
                 1, 2, 0, 32'h00001234, 1, 0,  1, 1);
    vecs[11] = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 2, 0, 32'hBBBB0000, 1, 1,  0, 1);
    // Queued load squashed by a later full-word ALU write.
    vecs[12] = v(1, 8, 0, 32'h1, 1, 1,  1, 3, 1, 32'h33333333, 1, 1,
                 1, 8, 0, 32'h1, 1, 1,  1, 1);
    vecs[13] = v(1, 3, 1, 32'h44444444, 0, 0,  0, 0, 0, 0, 0, 0,
                 1, 3, 1, 32'h44444444, 1, 1,  0, 1);
    vecs[14] = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1);
    vecs[15] = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1);
    // Hi-only load, then low-only ALU write: no squash, ALU first.
    vecs[16] = v(1, 8, 0, 32'h2, 1, 1,  1, 3, 0, 32'hAAAA0000, 1, 0,
                 1, 8, 0, 32'h2, 1, 1,  1, 1);
    vecs[17] = v(1, 3, 0, 32'h0000BBBB, 0, 1,  0, 0, 0, 0, 0, 0,
                 1, 3, 0, 32'h0000BBBB, 0, 1,  1, 1);
    vecs[18] = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 3, 0, 32'hAAAA0000, 1, 0,  0, 1);
    // Different bank: no squash.
    vecs[19] = v(1, 8, 0, 32'h3, 1, 1,  1, 3, 1, 32'h66, 1, 1,  1, 8, 0, 32'h3, 1, 1,  1, 1);
    vecs[20] = v(1, 3, 2, 32'h77, 1, 1,  0, 0, 0, 0, 0, 0,  1, 3, 2, 32'h77, 1, 1,  1, 1);
    vecs[21] = v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 3, 1, 32'h66, 1, 1,  0, 1);

    idle();
`ifdef WB_FWD_EN
    fwd_rsa_in = 5'd0; fwd_rsb_in = 5'd0; fwd_bank_in = 5'd0;
`endif
    reset_in = 1'b1;
    #1;
    check("reset.wb", 32'(wb_out), 32'h0);
    check("reset.pending", 32'(pending_out), 32'h0);
    check("reset.ready", 32'(mem_ready_out), 32'h1);
    check("reset.rd", 32'(wb_rd_out), 32'h0);
    check("reset.val", wb_val_out, 32'h0);
    step();
    step();
    reset_in = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].abk, vecs[i].aval, vecs[i].ahi, vecs[i].alo,
            vecs[i].mv, vecs[i].mrd, vecs[i].mbk, vecs[i].mval, vecs[i].mhi, vecs[i].mlo);
      step();
      check($sformatf("vec%0d.wb", i), 32'(wb_out), 32'(vecs[i].ewb));
      check($sformatf("vec%0d.pending", i), 32'(pending_out), 32'(vecs[i].epend));
      check($sformatf("vec%0d.ready", i), 32'(mem_ready_out), 32'(vecs[i].erdy));
      if (vecs[i].ewb) begin
        check($sformatf("vec%0d.rd", i), 32'(wb_rd_out), 32'(vecs[i].erd));
        check($sformatf("vec%0d.bank", i), 32'(wb_bank_sel_out), 32'(vecs[i].ebk));
        check($sformatf("vec%0d.val", i), wb_val_out, vecs[i].eval);
        check($sformatf("vec%0d.hi", i), 32'(wb_hi_out), 32'(vecs[i].ehi));
        check($sformatf("vec%0d.low", i), 32'(wb_low_out), 32'(vecs[i].elo));
      end
    end

    // Six ALU cycles with loads streaming: only four fit, then backpressure.
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 5'd1, 5'd0, 32'(k), 1'b1, 1'b1,
            1'b1, 5'(10 + k), 5'd0, 32'h100 + 32'(k), 1'b1, 1'b1);
      if (mem_ready_out) accepted++;
      step();
      check($sformatf("full%0d.ready", k), 32'(mem_ready_out), (k < 3) ? 32'h1 : 32'h0);
      check($sformatf("full%0d.pending", k), 32'(pending_out), (k < 3) ? 32'(k + 1) : 32'h4);
      check_wb($sformatf("full%0d.alu", k), 5'd1, 32'(k));
    end
    check("full.accepted", 32'(accepted), 32'h4);
    // Pop while full: this load must not be taken, ready rises only afterwards.
    drive(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd20, 5'd0, 32'h999, 1'b1, 1'b1);
    check("drain.ready_before", 32'(mem_ready_out), 32'h0);
    step();
    check("drain.ready_after", 32'(mem_ready_out), 32'h1);
    check_wb("drain0", 5'd10, 32'h100);
    idle();
    for (int k = 1; k < 4; k++) begin
      step();
      check_wb($sformatf("drain%0d", k), 5'(10 + k), 32'h100 + 32'(k));
    end
    step();
    check("drain.end_wb", 32'(wb_out), 32'h0);
    check("drain.end_pending", 32'(pending_out), 32'h0);

    // Reset in the middle of a drain.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd1, 5'd0, 32'h0, 1'b1, 1'b1,
            1'b1, 5'(12 + k), 5'd0, 32'h200 + 32'(k), 1'b1, 1'b1);
      step();
    end
    check("rst.pending_before", 32'(pending_out), 32'h3);
    idle();
    step();
    check_wb("rst.first_drain", 5'd12, 32'h200);
    #2;
    reset_in = 1'b1;
    #1;
    check("rst.wb", 32'(wb_out), 32'h0);
    check("rst.pending", 32'(pending_out), 32'h0);
    check("rst.ready", 32'(mem_ready_out), 32'h1);
    step();
    reset_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rst.stale%0d.wb", k), 32'(wb_out), 32'h0);
      check($sformatf("rst.stale%0d.pending", k), 32'(pending_out), 32'h0);
    end

`ifdef WB_FWD_EN
    drive(1'b1, 5'd7, 5'd2, 32'h12345678, 1'b0, 1'b0,
          1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    fwd_rsa_in = 5'd7; fwd_rsb_in = 5'd8; fwd_bank_in = 5'd2;
    step();
    check("fwd.a_hit", 32'(fwd_a_hit_out), 32'h1);
    check("fwd.a_val", fwd_a_val_out, 32'h12345678);
    check("fwd.b_hit", 32'(fwd_b_hit_out), 32'h0);
    check("fwd.b_val", fwd_b_val_out, 32'h0);
    idle();
    step();
    check("fwd.idle_hit", 32'(fwd_a_hit_out), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
